// File: rtl/ps2_host_rx_pkg.sv
// Shared PS/2 receiver definitions: FSM states, prefix bytes and the queued key-event layout.
package ps2_host_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;
  localparam int         EVT_W       = 10;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/ps2_host_rx_fifo.sv
// Synchronous show-ahead FIFO with registered head outputs, valid/ready pop side and overflow pulse.
module ps2_host_rx_fifo #(
  parameter int WIDTH     = 10,
  parameter int FIFO_BITS = 3
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             overflow
);

  localparam int DEPTH = 2 ** FIFO_BITS;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_BITS:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               valid_q, valid_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               pop, push_ok;

  assign full = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {FIFO_BITS{1'b0}}};

  always_comb begin
    pop      = valid_q & out_ready;
    push_ok  = push & (~full | pop);
    ovf_d    = push & ~push_ok;
    wr_ptr_d = wr_ptr_q + (FIFO_BITS+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (FIFO_BITS+1)'(pop);
    valid_d  = wr_ptr_d != rd_ptr_d;
    dout_d   = dout_q;
    // The new head may be the entry being written this very cycle.
    if (valid_d) begin
      if (push_ok && rd_ptr_d == wr_ptr_q) dout_d = din;
      else                                 dout_d = mem_q[rd_ptr_d[FIFO_BITS-1:0]];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= din;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign dout      = dout_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: sync + glitch filter, frame FSM with timeout, E0/F0 prefix folding into a key-event FIFO.
module ps2_host_rx
  import ps2_host_rx_pkg::*;
#(
  parameter int FILTER    = 4,
  parameter int TIMEOUT   = 20000,
  parameter int FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          strobe, din;
  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          done_q, done_d, err_q, err_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic          push, fifo_full;
  key_evt_t      evt_in, evt_out;

  assign din = dat_sync_q[1];

  // Filtered clock flips only after FILTER consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    strobe = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER - 1)) begin
        filt_d = clk_sync_q[1];
        strobe = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    to_d      = (state_q == ST_IDLE || strobe) ? '0 : to_q + 1'b1;
    if (!strobe && state_q != ST_IDLE && to_q == TW'(TIMEOUT - 1)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (!din) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_DATA: begin
          shreg_d   = {din, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = din;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (din && ^{shreg_q, par_q}) done_d = 1'b1;
          else                          err_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Prefix folding acts on the byte completed in the previous cycle.
  always_comb begin
    ext_d  = ext_q;
    rel_d  = rel_q;
    push   = 1'b0;
    evt_in = '{ext: ext_q, rel: rel_q, code: shreg_q};
    if (done_q) begin
      if (shreg_q == PS2_PFX_EXT)      ext_d = 1'b1;
      else if (shreg_q == PS2_PFX_REL) rel_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
    if (err_d) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      to_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      to_q       <= to_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
    end
  end

  ps2_host_rx_fifo #(.WIDTH(EVT_W), .FIFO_BITS(FIFO_BITS)) u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .push      (push),
    .din       (evt_in),
    .full      (fifo_full),
    .out_valid (key_valid),
    .out_ready (key_ready),
    .dout      (evt_out),
    .overflow  (overflow)
  );

  assign key_code    = evt_out.code;
  assign key_ext     = evt_out.ext;
  assign key_release = evt_out.rel;
  assign frame_err   = err_q;
  assign busy        = state_q != ST_IDLE;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: a PS/2 device BFM drives frames, each task checks its own scenario.
module tb_ps2_host_rx;

  localparam int FILTER  = 4;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 100;

  logic       clk_sys = 1'b0;
  logic       reset_n, ps2_clk, ps2_data, key_ready;
  logic       key_valid, key_ext, key_release, frame_err, overflow, busy;
  logic [7:0] key_code;

  int errors = 0, checks = 0;
  int ferr_cnt = 0, ovf_cnt = 0;
  int rise_lat;

  always #5 clk_sys = ~clk_sys;

  ps2_host_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_BITS(3)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .busy        (busy)
  );

  always @(negedge clk_sys) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (overflow === 1'b1)  ovf_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Device-side BFM: data changes while ps2_clk is high, host samples on the fall.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input int nbits, input int pop_at);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    rise_lat = -1;
    for (int k = 0; k < nbits; k++) begin
      ps2_data = bits[k];
      cyc(HALF);
      ps2_clk = 1'b0;
      for (int i = 1; i <= HALF; i++) begin
        @(posedge clk_sys);
        @(negedge clk_sys);
        if (k == 10) begin
          if (key_valid === 1'b1 && rise_lat < 0) rise_lat = i;
          if (pop_at > 0 && i == pop_at)          key_ready = 1'b1;
          else if (pop_at > 0 && i == pop_at + 1) key_ready = 1'b0;
        end
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    cyc(1);
    key_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; key_ready = 1'b0;
    cyc(3);
    checks++;
    if ({key_valid, key_code, key_ext, key_release, frame_err, overflow, busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b code=%h ext=%b rel=%b ferr=%b ovf=%b busy=%b want all 0",
               key_valid, key_code, key_ext, key_release, frame_err, overflow, busy);
    end
    reset_n = 1'b1;
    cyc(5);
  endtask

  task automatic test_single();
    int e0;
    e0 = ferr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 0);
    checks++;
    if (rise_lat !== FILTER + 3) begin
      errors++; $display("FAIL single_latency got %0d want %0d", rise_lat, FILTER + 3);
    end
    checks++;
    if ({key_valid, key_code, key_ext, key_release} !== {1'b1, 8'h1C, 2'b00}) begin
      errors++; $display("FAIL single_event got v=%b code=%h ext=%b rel=%b want v=1 code=1c ext=0 rel=0",
                         key_valid, key_code, key_ext, key_release);
    end
    checks++;
    if (ferr_cnt != e0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_status got ferr=%0d busy=%b want ferr=0 busy=0", ferr_cnt - e0, busy);
    end
    pop_one();
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop got valid=%b want 0", key_valid);
    end
  endtask

  task automatic test_prefix();
    send_frame(8'hE0, 1'b0, 1'b1, 11, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 0);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL prefix_no_event got valid=%b want 0", key_valid);
    end
    send_frame(8'h74, 1'b0, 1'b1, 11, 0);
    checks++;
    if ({key_valid, key_code, key_ext, key_release} !== {1'b1, 8'h74, 2'b11}) begin
      errors++; $display("FAIL prefix_event got v=%b code=%h ext=%b rel=%b want v=1 code=74 ext=1 rel=1",
                         key_valid, key_code, key_ext, key_release);
    end
    pop_one();
    send_frame(8'h1C, 1'b0, 1'b1, 11, 0);
    checks++;
    if ({key_valid, key_code, key_ext, key_release} !== {1'b1, 8'h1C, 2'b00}) begin
      errors++; $display("FAIL prefix_cleared got v=%b code=%h ext=%b rel=%b want v=1 code=1c ext=0 rel=0",
                         key_valid, key_code, key_ext, key_release);
    end
    pop_one();
  endtask

  task automatic test_errors();
    int e0;
    e0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11, 0);
    checks++;
    if (ferr_cnt != e0 + 1 || key_valid !== 1'b0) begin
      errors++; $display("FAIL parity_err got ferr=%0d valid=%b want ferr=1 valid=0", ferr_cnt - e0, key_valid);
    end
    send_frame(8'hF0, 1'b0, 1'b0, 11, 0);
    checks++;
    if (ferr_cnt != e0 + 2) begin
      errors++; $display("FAIL stop_err got ferr=%0d want 2", ferr_cnt - e0);
    end
    send_frame(8'h32, 1'b0, 1'b1, 11, 0);
    checks++;
    if ({key_valid, key_code, key_ext, key_release} !== {1'b1, 8'h32, 2'b00}) begin
      errors++; $display("FAIL err_clears_prefix got v=%b code=%h ext=%b rel=%b want v=1 code=32 ext=0 rel=0",
                         key_valid, key_code, key_ext, key_release);
    end
    pop_one();
  endtask

  task automatic test_timeout();
    int e0, w;
    e0 = ferr_cnt;
    send_frame(8'h2A, 1'b0, 1'b1, 6, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL timeout_busy_before got %b want 1", busy);
    end
    w = 0;
    while (ferr_cnt == e0 && w < TIMEOUT + 200) begin
      cyc(1);
      w++;
    end
    checks++;
    if (ferr_cnt != e0 + 1 || w < TIMEOUT / 2 || w >= TIMEOUT) begin
      errors++; $display("FAIL timeout_err got ferr=%0d after %0d cycles want 1 within (%0d..%0d)",
                         ferr_cnt - e0, w, TIMEOUT / 2, TIMEOUT);
    end
    checks++;
    if (busy !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_idle got busy=%b valid=%b want 0 0", busy, key_valid);
    end
    send_frame(8'h2A, 1'b0, 1'b1, 11, 0);
    checks++;
    if ({key_valid, key_code, key_ext, key_release} !== {1'b1, 8'h2A, 2'b00}) begin
      errors++; $display("FAIL timeout_recover got v=%b code=%h ext=%b rel=%b want v=1 code=2a",
                         key_valid, key_code, key_ext, key_release);
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    int o0;
    logic [7:0] exp_code;
    o0 = ovf_cnt;
    for (int n = 1; n <= 8; n++) send_frame(8'(n), 1'b0, 1'b1, 11, 0);
    checks++;
    if (ovf_cnt != o0 || key_valid !== 1'b1 || key_code !== 8'h01) begin
      errors++; $display("FAIL fill_head got ovf=%0d v=%b code=%h want ovf=0 v=1 code=01",
                         ovf_cnt - o0, key_valid, key_code);
    end
    send_frame(8'h09, 1'b0, 1'b1, 11, 0);
    checks++;
    if (ovf_cnt != o0 + 1 || key_code !== 8'h01) begin
      errors++; $display("FAIL overflow_drop got ovf=%0d code=%h want ovf=1 code=01", ovf_cnt - o0, key_code);
    end
    send_frame(8'h0A, 1'b0, 1'b1, 11, FILTER + 2);
    checks++;
    if (ovf_cnt != o0 + 1 || key_code !== 8'h02) begin
      errors++; $display("FAIL full_push_pop got ovf=%0d head=%h want ovf=1 head=02", ovf_cnt - o0, key_code);
    end
    for (int n = 0; n < 8; n++) begin
      exp_code = (n == 7) ? 8'h0A : 8'(n + 2);
      checks++;
      if (key_valid !== 1'b1 || key_code !== exp_code) begin
        errors++; $display("FAIL drain_%0d got v=%b code=%h want v=1 code=%h", n, key_valid, key_code, exp_code);
      end
      pop_one();
    end
    checks++;
    if (key_valid !== 1'b0 || key_code !== 8'h0A) begin
      errors++; $display("FAIL drain_empty got v=%b code=%h want v=0 code=0a (held)", key_valid, key_code);
    end
  endtask

  task automatic test_glitch_reset();
    int e0;
    e0 = ferr_cnt;
    ps2_clk = 1'b0;
    cyc(FILTER - 1);
    ps2_clk = 1'b1;
    cyc(20);
    checks++;
    if (ferr_cnt != e0 || busy !== 1'b0) begin
      errors++; $display("FAIL glitch_filtered got ferr=%0d busy=%b want 0 0", ferr_cnt - e0, busy);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 11, 0);
    send_frame(8'h33, 1'b0, 1'b1, 4, 0);
    checks++;
    if (busy !== 1'b1 || key_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset got busy=%b valid=%b want 1 1", busy, key_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({key_valid, key_code, key_ext, key_release, frame_err, overflow, busy} !== 14'd0) begin
      errors++; $display("FAIL midframe_reset got valid=%b code=%h busy=%b want all 0", key_valid, key_code, busy);
    end
    cyc(3);
    reset_n = 1'b1;
    cyc(5);
    send_frame(8'h66, 1'b0, 1'b1, 11, 0);
    checks++;
    if ({key_valid, key_code, key_ext, key_release} !== {1'b1, 8'h66, 2'b00}) begin
      errors++; $display("FAIL post_reset_frame got v=%b code=%h ext=%b rel=%b want v=1 code=66",
                         key_valid, key_code, key_ext, key_release);
    end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_glitch_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
